// File: rtl/xil_block_ram_1w1r_param.sv
// Purpose: parametrised 1-write/1-read block RAM split into bit-slice (NH) x address (NV) banks,
//          with clear-after-reset sweep, read-during-write bypass and a same-address conflict flag.
// Latency: read data on Q1 one cycle after CE1 (two with OUT_REG=1); no backpressure, READY=0 drops accesses.
module xil_block_ram_1w1r_param #(
  parameter int DATA_W       = 4,
  parameter int ADDR_W       = 13,
  parameter int BANK_W       = 2,
  parameter int BANK_AW      = 12,
  parameter int OUT_REG      = 0,
  parameter int BYPASS       = 1,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CE0,
  input  logic [ADDR_W-1:0] A0,
  input  logic [DATA_W-1:0] D0,
  input  logic              WE0,
  input  logic [DATA_W-1:0] WEM0,
  input  logic              CE1,
  input  logic [ADDR_W-1:0] A1,
  output logic [DATA_W-1:0] Q1,
  output logic              READY,
  output logic              CONFLICT
);

  localparam int NH    = (DATA_W + BANK_W - 1) / BANK_W;
  localparam int NV    = 1 << (ADDR_W - BANK_AW);
  localparam int PW    = NH * BANK_W;
  localparam int VW    = (ADDR_W > BANK_AW) ? (ADDR_W - BANK_AW) : 1;
  localparam int DEPTH = 1 << BANK_AW;

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;
  localparam state_t ST_RST = (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_RUN;

  state_t               r_state, w_state_nxt;
  logic [BANK_AW-1:0]   r_cnt, w_cnt_nxt;
  logic                 w_clr;
  logic                 r_ready;

  // state, clear counter and READY registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_RST;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= (w_state_nxt == ST_RUN);
    end
  end

  // clear sweep walks every bank address once, then RUN is terminal until reset
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_clr       = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_clr     = 1'b1;
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == '1) w_state_nxt = ST_RUN;
      end
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_RUN;
    endcase
  end

  assign READY = r_ready;

  // access decode; READY (not the raw state) gates the ports so the first
  // post-reset cycle of a no-clear build is also ignored
  logic [VW-1:0]      w_vsel0, w_vsel1;
  logic [BANK_AW-1:0] w_ab0, w_ab1;
  logic               w_wr, w_rd, w_coll;

  if (ADDR_W > BANK_AW) begin : g_vsel
    assign w_vsel0 = A0[ADDR_W-1:BANK_AW];
    assign w_vsel1 = A1[ADDR_W-1:BANK_AW];
  end else begin : g_vsel_none
    assign w_vsel0 = '0;
    assign w_vsel1 = '0;
  end

  assign w_ab0  = A0[BANK_AW-1:0];
  assign w_ab1  = A1[BANK_AW-1:0];
  assign w_wr   = r_ready & CE0 & WE0;
  assign w_rd   = r_ready & CE1;
  assign w_coll = w_wr & w_rd & (A0 == A1);

  // pad data with zeros and mask with ones so padding bits are always written 0
  logic [PW-1:0] w_dpad, w_mpad;
  always_comb begin
    w_dpad             = '0;
    w_mpad             = '1;
    w_dpad[DATA_W-1:0] = D0;
    w_mpad[DATA_W-1:0] = WEM0;
  end

  logic [BANK_W-1:0] w_bank_q [NV*NH];

  for (genvar v = 0; v < NV; v++) begin : g_v
    for (genvar h = 0; h < NH; h++) begin : g_h
      logic [BANK_W-1:0] r_mem [DEPTH];
      logic [BANK_W-1:0] r_q;
      logic              w_sel_wr, w_sel_rd;

      assign w_sel_wr = w_wr && (w_vsel0 == VW'(v));
      assign w_sel_rd = w_rd && (w_vsel1 == VW'(v));

      // array write: clear sweep has priority, otherwise bit-masked port-0 write
      always_ff @(posedge CLK) begin
        if (w_clr) begin
          r_mem[r_cnt] <= '0;
        end else if (w_sel_wr) begin
          for (int b = 0; b < BANK_W; b++) begin
            if (w_mpad[h*BANK_W+b]) r_mem[w_ab0][b] <= w_dpad[h*BANK_W+b];
          end
        end
      end

      // read-first capture: a same-cycle write is not yet visible here
      always_ff @(posedge CLK or posedge RST) begin
        if (RST)           r_q <= '0;
        else if (w_sel_rd) r_q <= r_mem[w_ab1];
      end

      assign w_bank_q[v*NH+h] = r_q;
    end
  end

  logic [VW-1:0]     r_vsel;
  logic              r_col, r_conf;
  logic [DATA_W-1:0] r_wd, r_wm;

  // read-side context; held between reads so Q1 stays stable while idle
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_vsel <= '0;
      r_col  <= 1'b0;
      r_wd   <= '0;
      r_wm   <= '0;
      r_conf <= 1'b0;
    end else begin
      r_conf <= w_coll;
      if (w_rd) begin
        r_vsel <= w_vsel1;
        r_col  <= w_coll;
        r_wd   <= D0;
        r_wm   <= WEM0;
      end
    end
  end

  logic [DATA_W-1:0] w_raw, w_q1s;

  // pick the selected vbank's slices and merge colliding write data when bypassing
  always_comb begin
    w_raw = '0;
    for (int i = 0; i < DATA_W; i++) begin
      w_raw[i] = w_bank_q[int'(r_vsel)*NH + i/BANK_W][i%BANK_W];
    end
    w_q1s = w_raw;
    if ((BYPASS != 0) && r_col) w_q1s = (r_wd & r_wm) | (w_raw & ~r_wm);
  end

  if (OUT_REG != 0) begin : g_oreg
    logic              r_rd1, r_conf2;
    logic [DATA_W-1:0] r_q2;

    // second stage only reloads when the first stage carries a fresh read
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        r_rd1   <= 1'b0;
        r_conf2 <= 1'b0;
        r_q2    <= '0;
      end else begin
        r_rd1   <= w_rd;
        r_conf2 <= r_conf;
        if (r_rd1) r_q2 <= w_q1s;
      end
    end

    assign Q1       = r_q2;
    assign CONFLICT = r_conf2;
  end else begin : g_onoreg
    assign Q1       = w_q1s;
    assign CONFLICT = r_conf;
  end

endmodule

// File: tb/tb_xil_block_ram_1w1r_param.sv
// Bench for xil_block_ram_1w1r_param: three instances (bypass/no-pipe, read-first/piped,
// odd-width no-clear) checked against word-level array models through per-instance
// expectation queues drained by independent monitors.
module tb_xil_block_ram_1w1r_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // shared stimulus for instances A and B
  logic        ab_ce0 = 0, ab_we0 = 0, ab_ce1 = 0;
  logic [12:0] ab_a0 = 0, ab_a1 = 0;
  logic [3:0]  ab_d0 = 0, ab_wem0 = 0;
  // stimulus for instance C
  logic        c_ce0 = 0, c_we0 = 0, c_ce1 = 0;
  logic [9:0]  c_a0 = 0, c_a1 = 0;
  logic [4:0]  c_d0 = 0, c_wem0 = 0;

  logic [3:0] qa_q1, qb_q1;
  logic [4:0] qc_q1;
  logic       qa_rdy, qb_rdy, qc_rdy, qa_conf, qb_conf, qc_conf;

  xil_block_ram_1w1r_param #(.DATA_W(4), .ADDR_W(13), .BANK_W(2), .BANK_AW(12),
    .OUT_REG(0), .BYPASS(1), .CLEAR_ON_RST(1)) u_a (
    .CLK(clk), .RST(rst), .CE0(ab_ce0), .A0(ab_a0), .D0(ab_d0), .WE0(ab_we0), .WEM0(ab_wem0),
    .CE1(ab_ce1), .A1(ab_a1), .Q1(qa_q1), .READY(qa_rdy), .CONFLICT(qa_conf));

  xil_block_ram_1w1r_param #(.DATA_W(4), .ADDR_W(13), .BANK_W(2), .BANK_AW(12),
    .OUT_REG(1), .BYPASS(0), .CLEAR_ON_RST(1)) u_b (
    .CLK(clk), .RST(rst), .CE0(ab_ce0), .A0(ab_a0), .D0(ab_d0), .WE0(ab_we0), .WEM0(ab_wem0),
    .CE1(ab_ce1), .A1(ab_a1), .Q1(qb_q1), .READY(qb_rdy), .CONFLICT(qb_conf));

  xil_block_ram_1w1r_param #(.DATA_W(5), .ADDR_W(10), .BANK_W(2), .BANK_AW(9),
    .OUT_REG(0), .BYPASS(1), .CLEAR_ON_RST(0)) u_c (
    .CLK(clk), .RST(rst), .CE0(c_ce0), .A0(c_a0), .D0(c_d0), .WE0(c_we0), .WEM0(c_wem0),
    .CE1(c_ce1), .A1(c_a1), .Q1(qc_q1), .READY(qc_rdy), .CONFLICT(qc_conf));

  int total = 0;
  int bad   = 0;
  int pcnt  = 0;   // posedges seen
  int since = 0;   // posedges seen with reset released

  always @(posedge clk) begin
    pcnt++;
    if (rst) since = 0;
    else     since++;
  end

  typedef struct {
    int         due;
    logic [7:0] d;
    logic       conf;
  } exp_t;

  exp_t       qa[$], qb[$], qc[$];
  logic [3:0] mab [8192];
  logic [4:0] mc  [1024];
  logic [7:0] la = 0, lb = 0, lc = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at pcnt=%0d", nm, act, exp, pcnt);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // one cycle of A/B traffic; a colliding read sees the new word when bypassing
  task automatic ab_op(input logic ce0, input logic we0, input logic [12:0] a0, input logic [3:0] d0,
                       input logic [3:0] m0, input logic ce1, input logic [12:0] a1);
    logic       run, coll;
    logic [3:0] oldv, newv;
    ab_ce0 = ce0; ab_we0 = we0; ab_a0 = a0; ab_d0 = d0; ab_wem0 = m0; ab_ce1 = ce1; ab_a1 = a1;
    run  = !rst && (since >= 4096);
    coll = ce0 && we0 && ce1 && (a0 == a1);
    oldv = mab[a1];
    newv = (d0 & m0) | (mab[a0] & ~m0);
    if (run && ce1) begin
      qa.push_back('{due: pcnt + 1, d: 8'(coll ? newv : oldv), conf: coll});
      qb.push_back('{due: pcnt + 2, d: 8'(oldv), conf: coll});
    end
    if (run && ce0 && we0) mab[a0] = newv;
    step();
    ab_ce0 = 0; ab_we0 = 0; ab_ce1 = 0;
  endtask

  task automatic c_op(input logic ce0, input logic we0, input logic [9:0] a0, input logic [4:0] d0,
                      input logic [4:0] m0, input logic ce1, input logic [9:0] a1);
    logic       run, coll;
    logic [4:0] oldv, newv;
    c_ce0 = ce0; c_we0 = we0; c_a0 = a0; c_d0 = d0; c_wem0 = m0; c_ce1 = ce1; c_a1 = a1;
    run  = !rst && (since >= 1);
    coll = ce0 && we0 && ce1 && (a0 == a1);
    oldv = mc[a1];
    newv = (d0 & m0) | (mc[a0] & ~m0);
    if (run && ce1) qc.push_back('{due: pcnt + 1, d: 8'(coll ? newv : oldv), conf: coll});
    if (run && ce0 && we0) mc[a0] = newv;
    step();
    c_ce0 = 0; c_we0 = 0; c_ce1 = 0;
  endtask

  // monitors: compare a due read, otherwise Q1 must hold and CONFLICT stay low
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (rst) la = 0;
    if (qa.size() != 0 && qa[0].due == pcnt) begin
      e = qa.pop_front();
      chk("a_q1", 8'(qa_q1), e.d);
      chk("a_conflict", 8'(qa_conf), 8'(e.conf));
      la = e.d;
    end else begin
      chk("a_q1_hold", 8'(qa_q1), la);
      chk("a_conflict_idle", 8'(qa_conf), 8'h00);
    end
    chk("a_ready", 8'(qa_rdy), 8'(!rst && since >= 4096));
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (rst) lb = 0;
    if (qb.size() != 0 && qb[0].due == pcnt) begin
      e = qb.pop_front();
      chk("b_q1", 8'(qb_q1), e.d);
      chk("b_conflict", 8'(qb_conf), 8'(e.conf));
      lb = e.d;
    end else begin
      chk("b_q1_hold", 8'(qb_q1), lb);
      chk("b_conflict_idle", 8'(qb_conf), 8'h00);
    end
    chk("b_ready", 8'(qb_rdy), 8'(!rst && since >= 4096));
  end

  always @(negedge clk) begin : mon_c
    exp_t e;
    if (rst) lc = 0;
    if (qc.size() != 0 && qc[0].due == pcnt) begin
      e = qc.pop_front();
      chk("c_q1", 8'(qc_q1), e.d);
      chk("c_conflict", 8'(qc_conf), 8'(e.conf));
      lc = e.d;
    end else begin
      chk("c_q1_hold", 8'(qc_q1), lc);
      chk("c_conflict_idle", 8'(qc_conf), 8'h00);
    end
    chk("c_ready", 8'(qc_rdy), 8'(!rst && since >= 1));
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at pcnt=%0d", pcnt);
    $fatal(1, "watchdog");
  end

  function automatic logic [12:0] ab_pick();
    return {1'($urandom), 8'h00, 4'($urandom)};
  endfunction

  initial begin
    logic [12:0] a0, a1;
    logic [9:0]  c0, c1;
    for (int i = 0; i < 8192; i++) mab[i] = 4'h0;
    repeat (3) step();
    rst = 0;
    fork
      begin
        // accesses during the clear sweep are dropped
        ab_op(1, 1, 13'h0055, 4'hF, 4'hF, 0, 13'h0000);
        ab_op(0, 0, 13'h0000, 4'h0, 4'h0, 1, 13'h0055);
        while (since < 4096) step();
        ab_op(0, 0, 13'h0000, 4'h0, 4'h0, 1, 13'h0055);
        ab_op(0, 0, 13'h0000, 4'h0, 4'h0, 1, 13'h1FFF);
        ab_op(0, 0, 13'h0000, 4'h0, 4'h0, 1, 13'h0000);
      end
      begin
        while (since < 1) step();
        for (int i = 0; i < 1024; i++) c_op(1, 1, 10'(i), 5'($urandom), 5'h1F, 0, 10'h000);
        for (int i = 0; i < 500; i++) begin
          c0 = 10'($urandom);
          c1 = ($urandom_range(0, 2) == 0) ? c0 : 10'($urandom);
          c_op(1'($urandom), ($urandom_range(0, 3) != 0), c0, 5'($urandom), 5'($urandom),
               1'($urandom), c1);
        end
      end
    join

    // masked write then reads in both vbanks
    ab_op(1, 1, 13'h1ABC, 4'hF, 4'b0101, 0, 13'h0000);
    ab_op(0, 0, 13'h0000, 4'h0, 4'h0, 1, 13'h1ABC);
    ab_op(0, 0, 13'h0000, 4'h0, 4'h0, 1, 13'h0ABC);
    // same-address collision
    ab_op(1, 1, 13'h0010, 4'hA, 4'hF, 0, 13'h0000);
    ab_op(1, 1, 13'h0010, 4'h5, 4'b0011, 1, 13'h0010);
    ab_op(0, 0, 13'h0000, 4'h0, 4'h0, 1, 13'h0010);
    // read then idle: Q1 must hold
    ab_op(0, 0, 13'h0000, 4'h0, 4'h0, 1, 13'h1ABC);
    repeat (10) step();

    for (int i = 0; i < 300; i++) begin
      a0 = ab_pick();
      a1 = ($urandom_range(0, 2) == 0) ? a0 : ab_pick();
      ab_op(1'($urandom), ($urandom_range(0, 3) != 0), a0, 4'($urandom), 4'($urandom),
            1'($urandom), a1);
    end

    // leave a nonzero word on Q1, drain, then reset
    ab_op(0, 0, 13'h0000, 4'h0, 4'h0, 1, 13'h1ABC);
    repeat (4) step();
    rst = 1;
    for (int i = 0; i < 8192; i++) mab[i] = 4'h0;
    #1;
    chk("rst_q1_a", 8'(qa_q1), 8'h00);
    chk("rst_q1_b", 8'(qb_q1), 8'h00);
    chk("rst_ready_a", 8'(qa_rdy), 8'h00);
    step(); step();
    rst = 0;
    ab_op(1, 1, 13'h0777, 4'hF, 4'hF, 0, 13'h0000);
    repeat (98) step();
    // reset again mid-clear
    rst = 1;
    #1;
    chk("midclr_q1_a", 8'(qa_q1), 8'h00);
    chk("midclr_ready_a", 8'(qa_rdy), 8'h00);
    chk("midclr_ready_b", 8'(qb_rdy), 8'h00);
    step(); step();
    rst = 0;
    while (since < 4096) step();
    ab_op(0, 0, 13'h0000, 4'h0, 4'h0, 1, 13'h0777);
    ab_op(0, 0, 13'h0000, 4'h0, 4'h0, 1, 13'h1ABC);
    ab_op(0, 0, 13'h0000, 4'h0, 4'h0, 1, 13'h0010);
    // the no-clear instance keeps its contents across reset
    for (int i = 0; i < 8; i++) c_op(0, 0, 10'h000, 5'h00, 5'h00, 1, 10'($urandom));
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
